// File: rtl/video_dnn_argmax_count_pipe_pkg.sv
// Shared helpers, tree sizing functions and the (index,count) pair type used
// by the per-pixel argmax pipeline.
package video_dnn_argmax_count_pipe_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Number of candidates alive after lvl halvings (odd leftovers survive).
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int level_offset(input int n, input int lvl);
    int o;
    o = 0;
    for (int i = 0; i < lvl; i++) o = o + level_count(n, i);
    return o;
  endfunction

  localparam int NUM_CLASS_DEFAULT = 11;
  localparam int TREE_DEPTH        = clog2(NUM_CLASS_DEFAULT);
  localparam int NONE_CLASS        = NUM_CLASS_DEFAULT;

  // Sized for the largest legal configuration (64 classes, 64 votes).
  localparam int PAIR_IDX_W = 7;
  localparam int PAIR_CNT_W = 7;

  typedef struct packed {
    logic [PAIR_IDX_W-1:0] idx;
    logic [PAIR_CNT_W-1:0] cnt;
  } pair_t;

endpackage

// File: rtl/video_dnn_argmax_tree_stage.sv
// One registered level of the argmax tree: pairs neighbours, keeps the left
// candidate unless the right one has a strictly larger count.
module video_dnn_argmax_tree_stage
  import video_dnn_argmax_count_pipe_pkg::*;
#(
  parameter  int N_IN  = 11,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cke,
  input  logic                in_valid,
  input  pair_t [N_IN-1:0]    in_pairs,
  output logic                out_valid,
  output pair_t [N_OUT-1:0]   out_pairs
);

  pair_t [N_OUT-1:0] nxt;

  for (genvar i = 0; i < N_OUT; i++) begin : g_pair
    if (2 * i + 1 < N_IN) begin : g_cmp
      assign nxt[i] = (in_pairs[2*i+1].cnt > in_pairs[2*i].cnt) ? in_pairs[2*i+1]
                                                                  : in_pairs[2*i];
    end else begin : g_pass
      assign nxt[i] = in_pairs[2*i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_pairs <= '0;
    end else if (cke) begin
      out_valid <= in_valid;
      out_pairs <= nxt;
    end
  end

endmodule

// File: rtl/video_dnn_argmax_count_pipe.sv
// Per-pixel class decision: popcount each vote group, pick the winner through
// a registered comparison tree, and apply the per-frame minimum-count threshold.
module video_dnn_argmax_count_pipe
  import video_dnn_argmax_count_pipe_pkg::*;
#(
  parameter int NUM_CLASS     = NUM_CLASS_DEFAULT,
  parameter int CHANNEL_WIDTH = 4,
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = clog2(CHANNEL_WIDTH + 1),
  parameter int TDATA_WIDTH   = NUM_CLASS * CHANNEL_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TCOUNT_WIDTH-1:0]  param_th,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  localparam int D      = clog2(NUM_CLASS);
  localparam int TREE_N = level_offset(NUM_CLASS, D + 1);

  if (NUM_CLASS < 2 || NUM_CLASS > 64 || CHANNEL_WIDTH < 1 || CHANNEL_WIDTH > 64 ||
      TUSER_WIDTH < 1 || TNUMBER_WIDTH > PAIR_IDX_W || (1 << TNUMBER_WIDTH) <= NUM_CLASS ||
      TCOUNT_WIDTH > PAIR_CNT_W || (1 << TCOUNT_WIDTH) <= CHANNEL_WIDTH ||
      TDATA_WIDTH != NUM_CLASS * CHANNEL_WIDTH) begin : g_bad_param
    $error("video_dnn_argmax_count_pipe: illegal parameter combination");
  end

  logic                    cke;
  logic                    frame_start;
  logic [TCOUNT_WIDTH-1:0] th_q;
  logic [TCOUNT_WIDTH-1:0] beat_th;
  pair_t [NUM_CLASS-1:0]   pc;
  pair_t [NUM_CLASS-1:0]   s0_pairs;
  logic                    s0_valid;
  pair_t [TREE_N-1:0]      tree;
  logic [D:0]              valid_chain;
  pair_t                   win;
  logic                    below_th;
  logic                    unused_idx;

  logic [TUSER_WIDTH-1:0]  sb_user [D+1];
  logic                    sb_last [D+1];
  logic [TDATA_WIDTH-1:0]  sb_data [D+1];
  logic [TCOUNT_WIDTH-1:0] sb_th   [D+1];

  assign cke            = m_axi4s_tready | ~m_axi4s_tvalid;
  assign s_axi4s_tready = cke;
  assign frame_start    = s_axi4s_tvalid & cke & s_axi4s_tuser[0];
  // A frame-start beat already uses the threshold it brings with it.
  assign beat_th        = frame_start ? param_th : th_q;

  always_comb begin
    pc = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      pc[k].idx = PAIR_IDX_W'(k);
      for (int b = 0; b < CHANNEL_WIDTH; b++) begin
        pc[k].cnt = pc[k].cnt + PAIR_CNT_W'(s_axi4s_tdata[k*CHANNEL_WIDTH+b]);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      th_q     <= '0;
      s0_valid <= 1'b0;
      s0_pairs <= '0;
      for (int i = 0; i <= D; i++) begin
        sb_user[i] <= '0;
        sb_last[i] <= 1'b0;
        sb_data[i] <= '0;
        sb_th[i]   <= '0;
      end
    end else if (cke) begin
      if (frame_start) th_q <= param_th;
      s0_valid   <= s_axi4s_tvalid;
      s0_pairs   <= pc;
      sb_user[0] <= s_axi4s_tuser;
      sb_last[0] <= s_axi4s_tlast;
      sb_data[0] <= s_axi4s_tdata;
      sb_th[0]   <= beat_th;
      for (int i = 1; i <= D; i++) begin
        sb_user[i] <= sb_user[i-1];
        sb_last[i] <= sb_last[i-1];
        sb_data[i] <= sb_data[i-1];
        sb_th[i]   <= sb_th[i-1];
      end
    end
  end

  assign tree[NUM_CLASS-1:0] = s0_pairs;
  assign valid_chain[0]      = s0_valid;

  // Level l of the tree lives at tree[level_offset(l) +: level_count(l)].
  for (genvar l = 1; l <= D; l++) begin : g_tree
    localparam int NI = level_count(NUM_CLASS, l - 1);
    localparam int NO = level_count(NUM_CLASS, l);
    localparam int OI = level_offset(NUM_CLASS, l - 1);
    localparam int OO = level_offset(NUM_CLASS, l);
    video_dnn_argmax_tree_stage #(.N_IN(NI)) u_stage (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cke       (cke),
      .in_valid  (valid_chain[l-1]),
      .in_pairs  (tree[OI +: NI]),
      .out_valid (valid_chain[l]),
      .out_pairs (tree[OO +: NO])
    );
  end

  assign win      = tree[TREE_N-1];
  assign below_th = (sb_th[D] != '0) && (win.cnt < PAIR_CNT_W'(sb_th[D]));

  if (TNUMBER_WIDTH < PAIR_IDX_W) begin : g_idx_trim
    assign unused_idx = ^win.idx[PAIR_IDX_W-1:TNUMBER_WIDTH];
  end else begin : g_idx_full
    assign unused_idx = 1'b0;
  end

  assign m_axi4s_tvalid  = valid_chain[D];
  assign m_axi4s_tuser   = sb_user[D];
  assign m_axi4s_tlast   = sb_last[D];
  assign m_axi4s_tdata   = sb_data[D];
  assign m_axi4s_tcount  = win.cnt[TCOUNT_WIDTH-1:0];
  assign m_axi4s_tnumber = below_th ? TNUMBER_WIDTH'(NUM_CLASS) : win.idx[TNUMBER_WIDTH-1:0];

endmodule

// File: tb/tb_video_dnn_argmax_count_pipe.sv
// Self-checking bench for the argmax pipe: directed vector table, random
// backpressure stream and mid-stream reset, all checked through a scoreboard.
module tb_video_dnn_argmax_count_pipe;

  localparam int NC = 11;
  localparam int CW = 4;
  localparam int TW = NC * CW;
  localparam int LATENCY = 5;

  typedef struct {
    logic [TW-1:0] data;
    logic          user;
    logic          last;
    logic [2:0]    th;
    logic [3:0]    exp_num;
    logic [2:0]    exp_cnt;
  } vec_t;

  typedef struct {
    logic [TW-1:0] data;
    logic          user;
    logic          last;
    logic [3:0]    num;
    logic [2:0]    cnt;
  } exp_t;

  logic          aclk;
  logic          aresetn;
  logic [2:0]    param_th;
  logic [0:0]    s_axi4s_tuser;
  logic          s_axi4s_tlast;
  logic [TW-1:0] s_axi4s_tdata;
  logic          s_axi4s_tvalid;
  logic          s_axi4s_tready;
  logic [0:0]    m_axi4s_tuser;
  logic          m_axi4s_tlast;
  logic [3:0]    m_axi4s_tnumber;
  logic [2:0]    m_axi4s_tcount;
  logic [TW-1:0] m_axi4s_tdata;
  logic          m_axi4s_tvalid;
  logic          m_axi4s_tready;

  int   checks;
  int   failures;
  int   ready_mode;
  logic [2:0] th_model;
  exp_t exp_q[$];
  logic stall_pending;
  logic [63:0] stall_snap;
  logic [63:0] out_vec;
  vec_t vecs [12];

  video_dnn_argmax_count_pipe #(
    .NUM_CLASS(NC), .CHANNEL_WIDTH(CW), .TUSER_WIDTH(1), .TNUMBER_WIDTH(4),
    .TCOUNT_WIDTH(3), .TDATA_WIDTH(TW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .param_th(param_th),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tnumber(m_axi4s_tnumber), .m_axi4s_tcount(m_axi4s_tcount),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Output ready changes 2 time units after the rising edge, so it is stable at every falling edge.
  initial begin
    m_axi4s_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      case (ready_mode)
        0:       m_axi4s_tready = 1'b1;
        1:       m_axi4s_tready = 1'($urandom_range(0, 1));
        default: m_axi4s_tready = 1'b0;
      endcase
    end
  end

  assign out_vec = {10'b0, m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast,
                    m_axi4s_tnumber, m_axi4s_tcount, m_axi4s_tdata};

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void refModel(input logic [TW-1:0] d, input logic [2:0] th,
                                   output logic [3:0] num, output logic [2:0] cnt);
    int best;
    int idx;
    int c;
    logic [CW-1:0] grp;
    best = 0;
    idx  = 0;
    for (int k = 0; k < NC; k++) begin
      grp = d[k*CW +: CW];
      c = $countones(grp);
      if (c > best) begin
        best = c;
        idx  = k;
      end
    end
    cnt = 3'(best);
    num = (th != 3'd0 && best < int'(th)) ? 4'(NC) : 4'(idx);
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic applyStimulus(input logic [TW-1:0] d, input logic u, input logic l,
                               input logic [2:0] th, input logic [3:0] en, input logic [2:0] ec);
    int   waited;
    exp_t e;
    s_axi4s_tdata  = d;
    s_axi4s_tuser  = u;
    s_axi4s_tlast  = l;
    param_th       = th;
    s_axi4s_tvalid = 1'b1;
    waited = 0;
    while (!s_axi4s_tready && waited < 200) begin
      @(negedge aclk);
      waited++;
    end
    if (!s_axi4s_tready) begin
      checks++;
      failures++;
      $display("[TB] FAIL input_accept_timeout got=tready_low expected=tready_high");
    end else begin
      e.data = d; e.user = u; e.last = l; e.num = en; e.cnt = ec;
      exp_q.push_back(e);
      @(negedge aclk);
    end
    s_axi4s_tvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout got=%0d_pending expected=0_pending", exp_q.size());
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) checkOutput("stall_hold", out_vec, stall_snap);
      stall_pending = m_axi4s_tvalid && !m_axi4s_tready;
      stall_snap    = out_vec;
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat got=tvalid expected=no_beat at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tnumber", 64'(m_axi4s_tnumber), 64'(e.num));
          checkOutput("tcount",  64'(m_axi4s_tcount),  64'(e.cnt));
          checkOutput("tdata",   64'(m_axi4s_tdata),   64'(e.data));
          checkOutput("tuser",   64'(m_axi4s_tuser),   64'(e.user));
          checkOutput("tlast",   64'(m_axi4s_tlast),   64'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0]   r;
    logic [TW-1:0] d;
    logic          u;
    logic          l;
    logic [2:0]    th;
    logic [3:0]    en;
    logic [2:0]    ec;
    int            n;

    checks = 0; failures = 0; ready_mode = 0; th_model = 3'd0; stall_pending = 1'b0;
    stall_snap = '0;
    aresetn = 1'b0; param_th = '0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0;
    s_axi4s_tdata = '0; s_axi4s_tvalid = 1'b0;

    vecs[0]  = '{44'h0000000B000, 1'b1, 1'b0, 3'd0, 4'd3,  3'd3};
    vecs[1]  = '{44'h00050000301, 1'b0, 1'b0, 3'd0, 4'd2,  3'd2};
    vecs[2]  = '{44'h00000000000, 1'b0, 1'b0, 3'd0, 4'd0,  3'd0};
    vecs[3]  = '{44'hFFFFFFFFFFF, 1'b0, 1'b1, 3'd0, 4'd0,  3'd4};
    vecs[4]  = '{44'hF7777777777, 1'b0, 1'b0, 3'd0, 4'd10, 3'd4};
    vecs[5]  = '{44'h00000600010, 1'b1, 1'b0, 3'd3, 4'd11, 3'd2};
    vecs[6]  = '{44'h00000F00000, 1'b0, 1'b0, 3'd0, 4'd5,  3'd4};
    vecs[7]  = '{44'h03000010000, 1'b0, 1'b1, 3'd0, 4'd11, 3'd2};
    vecs[8]  = '{44'h00008000000, 1'b1, 1'b0, 3'd0, 4'd6,  3'd1};
    vecs[9]  = '{44'hFFFFFFFFFFF, 1'b1, 1'b0, 3'd4, 4'd0,  3'd4};
    vecs[10] = '{44'h00700000000, 1'b0, 1'b0, 3'd7, 4'd11, 3'd3};
    vecs[11] = '{44'h0000000007B, 1'b1, 1'b1, 3'd0, 4'd0,  3'd3};

    repeat (3) @(negedge aclk);
    checkOutput("rst_tvalid",  64'(m_axi4s_tvalid),  64'd0);
    checkOutput("rst_tnumber", 64'(m_axi4s_tnumber), 64'd0);
    checkOutput("rst_tcount",  64'(m_axi4s_tcount),  64'd0);
    checkOutput("rst_tdata",   64'(m_axi4s_tdata),   64'd0);
    checkOutput("rst_tready",  64'(s_axi4s_tready),  64'd1);
    aresetn = 1'b1;
    @(negedge aclk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].data, vecs[i].user, vecs[i].last, vecs[i].th,
                    vecs[i].exp_num, vecs[i].exp_cnt);
    end
    waitDrain();

    $display("[TB] random stream with backpressure");
    ready_mode = 1;
    for (int i = 0; i < 100; i++) begin
      r  = {$urandom, $urandom};
      d  = r[TW-1:0];
      u  = (i == 0);
      l  = (i == 27);
      th = 3'($urandom_range(0, 4));
      if (u) th_model = th;
      refModel(d, th_model, en, ec);
      if ($urandom_range(0, 3) == 0) @(negedge aclk);
      applyStimulus(d, u, l, th, en, ec);
    end
    waitDrain();

    $display("[TB] reset with beats in flight");
    ready_mode = 2;
    @(posedge aclk);
    @(negedge aclk);
    applyStimulus(44'h00000000F00, 1'b1, 1'b0, 3'd2, 4'd2, 3'd4);
    applyStimulus(44'h00000000030, 1'b0, 1'b0, 3'd0, 4'd1, 3'd2);
    applyStimulus(44'h00000000001, 1'b0, 1'b0, 3'd0, 4'd11, 3'd1);
    n = 0;
    while (!m_axi4s_tvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("stalled_tvalid", 64'(m_axi4s_tvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("async_rst_tvalid",  64'(m_axi4s_tvalid),  64'd0);
    checkOutput("async_rst_tnumber", 64'(m_axi4s_tnumber), 64'd0);
    checkOutput("async_rst_tdata",   64'(m_axi4s_tdata),   64'd0);
    exp_q.delete();
    th_model = 3'd0;
    ready_mode = 0;
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    repeat (6) begin
      @(negedge aclk);
      checkOutput("post_rst_idle", 64'(m_axi4s_tvalid), 64'd0);
    end
    // Threshold must be back to 0: a single vote still wins.
    applyStimulus(44'h00008000000, 1'b0, 1'b0, 3'd5, 4'd6, 3'd1);
    n = 1;
    while (!m_axi4s_tvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("latency", 64'(n), 64'(LATENCY));
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
